// File: rtl/dca_matrix_sequencer.sv
// Element-stream generator for DCA matrix traversal: walks a rows x cols matrix
// in row- or column-major order and emits one address descriptor per handshake.
module dca_matrix_sequencer #(
    parameter int BW_NUM_ROW = 8,
    parameter int BW_NUM_COL = 8,
    parameter int BW_ADDR    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  is_col_first,
    input  logic [BW_NUM_ROW-1:0] num_row_m1,
    input  logic [BW_NUM_COL-1:0] num_col_m1,
    input  logic [BW_ADDR-1:0]    base_addr,
    input  logic [BW_ADDR-1:0]    row_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BW_NUM_ROW-1:0] out_row,
    output logic [BW_NUM_COL-1:0] out_col,
    output logic [BW_ADDR-1:0]    out_addr,
    output logic                  out_is_first_x,
    output logic                  out_is_last_x,
    output logic                  out_is_first_y,
    output logic                  out_is_last_y,
    output logic                  out_is_last_element
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic                  col_first_reg, col_first_next;
    logic [BW_NUM_ROW-1:0] nrow_reg, nrow_next;
    logic [BW_NUM_COL-1:0] ncol_reg, ncol_next;
    logic [BW_ADDR-1:0]    stride_reg, stride_next;
    logic [BW_NUM_ROW-1:0] row_reg, row_next;
    logic [BW_NUM_COL-1:0] col_reg, col_next;
    logic [BW_ADDR-1:0]    addr_reg, addr_next;
    // Address of (row, 0) and of (0, col): lets both wrap cases avoid a multiplier.
    logic [BW_ADDR-1:0]    row_base_reg, row_base_next;
    logic [BW_ADDR-1:0]    col_base_reg, col_base_next;

    logic last_row, last_col, last_elem, first_row, first_col;

    assign last_row  = (row_reg == nrow_reg);
    assign last_col  = (col_reg == ncol_reg);
    assign first_row = (row_reg == '0);
    assign first_col = (col_reg == '0);
    assign last_elem = last_row && last_col;

    always_comb begin
        state_next     = state_reg;
        col_first_next = col_first_reg;
        nrow_next      = nrow_reg;
        ncol_next      = ncol_reg;
        stride_next    = stride_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        addr_next      = addr_reg;
        row_base_next  = row_base_reg;
        col_base_next  = col_base_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    col_first_next = is_col_first;
                    nrow_next      = num_row_m1;
                    ncol_next      = num_col_m1;
                    stride_next    = row_stride;
                    row_next       = '0;
                    col_next       = '0;
                    addr_next      = base_addr;
                    row_base_next  = base_addr;
                    col_base_next  = base_addr;
                    state_next     = S_RUN;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    if (last_elem) begin
                        state_next = S_DONE;
                    end else if (col_first_reg) begin
                        if (!last_col) begin
                            col_next  = col_reg + 1'b1;
                            addr_next = addr_reg + 1'b1;
                        end else begin
                            col_next      = '0;
                            row_next      = row_reg + 1'b1;
                            addr_next     = row_base_reg + stride_reg;
                            row_base_next = row_base_reg + stride_reg;
                        end
                    end else begin
                        if (!last_row) begin
                            row_next  = row_reg + 1'b1;
                            addr_next = addr_reg + stride_reg;
                        end else begin
                            row_next      = '0;
                            col_next      = col_reg + 1'b1;
                            addr_next     = col_base_reg + 1'b1;
                            col_base_next = col_base_reg + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort takes priority over everything, including a start in IDLE.
        if (clear) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            col_first_reg <= 1'b0;
            nrow_reg      <= '0;
            ncol_reg      <= '0;
            stride_reg    <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            addr_reg      <= '0;
            row_base_reg  <= '0;
            col_base_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            col_first_reg <= col_first_next;
            nrow_reg      <= nrow_next;
            ncol_reg      <= ncol_next;
            stride_reg    <= stride_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            addr_reg      <= addr_next;
            row_base_reg  <= row_base_next;
            col_base_reg  <= col_base_next;
        end
    end

    assign busy      = (state_reg == S_RUN);
    assign out_valid = (state_reg == S_RUN);
    assign done      = (state_reg == S_DONE);
    assign out_row   = row_reg;
    assign out_col   = col_reg;
    assign out_addr  = addr_reg;

    // x is the inner dimension: col when col-first, row otherwise.
    assign out_is_first_x      = out_valid && (col_first_reg ? first_col : first_row);
    assign out_is_last_x       = out_valid && (col_first_reg ? last_col  : last_row);
    assign out_is_first_y      = out_valid && (col_first_reg ? first_row : first_col);
    assign out_is_last_y       = out_valid && (col_first_reg ? last_row  : last_col);
    assign out_is_last_element = out_valid && last_elem;

endmodule

// File: tb/tb_dca_matrix_sequencer.sv
// Scoreboard bench for dca_matrix_sequencer: stimulus pushes expected
// descriptors/done events, a negedge monitor pops and compares them.
module tb_dca_matrix_sequencer;

    logic        clk = 1'b0;
    logic        rst, clear, start, is_col_first, out_ready;
    logic [7:0]  num_row_m1, num_col_m1;
    logic [15:0] base_addr, row_stride;
    logic        busy, done, out_valid;
    logic [7:0]  out_row, out_col;
    logic [15:0] out_addr;
    logic        out_is_first_x, out_is_last_x, out_is_first_y, out_is_last_y, out_is_last_element;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        is_done;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [15:0] addr;
        logic [4:0]  flags;   // first_x, last_x, first_y, last_y, last_element
    } item_t;

    item_t sb_q[$];

    dca_matrix_sequencer #(.BW_NUM_ROW(8), .BW_NUM_COL(8), .BW_ADDR(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .clear              (clear),
        .start              (start),
        .is_col_first       (is_col_first),
        .num_row_m1         (num_row_m1),
        .num_col_m1         (num_col_m1),
        .base_addr          (base_addr),
        .row_stride         (row_stride),
        .busy               (busy),
        .done               (done),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_row            (out_row),
        .out_col            (out_col),
        .out_addr           (out_addr),
        .out_is_first_x     (out_is_first_x),
        .out_is_last_x      (out_is_last_x),
        .out_is_first_y     (out_is_first_y),
        .out_is_last_y      (out_is_last_y),
        .out_is_last_element(out_is_last_element)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    task automatic push_elem(input int r, input int c, input logic [15:0] a, input logic [4:0] f);
        item_t it;
        it.is_done = 1'b0;
        it.row     = 8'(r);
        it.col     = 8'(c);
        it.addr    = a;
        it.flags   = f;
        sb_q.push_back(it);
    endtask

    task automatic push_done();
        item_t it;
        it = '0;
        it.is_done = 1'b1;
        sb_q.push_back(it);
    endtask

    // Reference traversal using a direct address formula.
    task automatic push_matrix(input logic cf, input int nr, input int nc,
                               input logic [15:0] base, input logic [15:0] stride);
        int outer_n, inner_n, r, c;
        logic [4:0] f;
        outer_n = cf ? nr : nc;
        inner_n = cf ? nc : nr;
        for (int o = 0; o <= outer_n; o++) begin
            for (int i = 0; i <= inner_n; i++) begin
                r = cf ? o : i;
                c = cf ? i : o;
                f = {i == 0, i == inner_n, o == 0, o == outer_n, (r == nr) && (c == nc)};
                push_elem(r, c, 16'(int'(base) + r * int'(stride) + c), f);
            end
        end
        push_done();
    endtask

    // Monitor: compares every handshake and done pulse against the scoreboard.
    item_t stall_snap;
    logic  stall_prev = 1'b0;
    always @(negedge clk) begin
        item_t got, exp;
        got = {1'b0, out_row, out_col, out_addr,
               {out_is_first_x, out_is_last_x, out_is_first_y, out_is_last_y, out_is_last_element}};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (done) begin
                n_cmp++;
                if (out_valid) begin
                    n_err++;
                    $display("FAIL done_vs_valid: got out_valid=1 with done=1 required out_valid=0");
                end else if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_pulse: got unexpected done required no done");
                end else begin
                    exp = sb_q.pop_front();
                    if (!exp.is_done) begin
                        n_err++;
                        $display("FAIL done_pulse: got done required element r=%0d c=%0d", exp.row, exp.col);
                    end else begin
                        $display("ok   done_pulse");
                    end
                end
            end
            if (stall_prev && out_valid) begin
                n_cmp++;
                if (got !== stall_snap) begin
                    n_err++;
                    $display("FAIL stall_hold: got 0x%0h required 0x%0h", got, stall_snap);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL xfer: got r=%0d c=%0d a=0x%0h required no transfer", out_row, out_col, out_addr);
                end else begin
                    exp = sb_q.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL xfer: got r=%0d c=%0d a=0x%0h f=%b required r=%0d c=%0d a=0x%0h f=%b done=%0d",
                                 out_row, out_col, out_addr, got.flags, exp.row, exp.col, exp.addr, exp.flags, exp.is_done);
                    end else begin
                        $display("xfer r=%0d c=%0d a=0x%0h f=%b", out_row, out_col, out_addr, got.flags);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_snap = got;
        end
    end

    // Starts a run; entered and left at posedge+1. Leaves the bench in cycle T+1.
    task automatic do_start(input logic cf, input int nr, input int nc,
                            input logic [15:0] base, input logic [15:0] stride);
        is_col_first = cf;
        num_row_m1   = 8'(nr);
        num_col_m1   = 8'(nc);
        base_addr    = base;
        row_stride   = stride;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        is_col_first = ~cf;
        num_row_m1   = 8'hA5;
        num_col_m1   = 8'h5A;
        base_addr    = 16'hDEAD;
        row_stride   = 16'hBEEF;
        chk("start_latency_valid", 64'(out_valid), 64'd1);
        chk("start_first_addr", 64'(out_addr), 64'(base));
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        int k;
        k = 0;
        while (!done && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done in %0d cycles required done", name, k);
        end else begin
            if (exp_edges >= 0) chk({name, "_done_cycle"}, 64'(k), 64'(exp_edges));
            @(posedge clk); #1;
            chk({name, "_idle_after_done"}, 64'({busy, done, out_valid}), 64'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {25'd0, busy, done, out_valid, out_row, out_col, out_addr,
                   out_is_first_x, out_is_last_x, out_is_first_y, out_is_last_y, out_is_last_element},
            64'd0);
    endtask

    initial begin
        logic [0:7] pat;
        rst = 1'b1; clear = 1'b0; start = 1'b0; out_ready = 1'b1;
        is_col_first = 1'b0; num_row_m1 = '0; num_col_m1 = '0;
        base_addr = '0; row_stride = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("idle_after_reset");

        // Col-first 2x3
        push_elem(0, 0, 16'h0100, 5'b10100);
        push_elem(0, 1, 16'h0101, 5'b00100);
        push_elem(0, 2, 16'h0102, 5'b01100);
        push_elem(1, 0, 16'h0110, 5'b10010);
        push_elem(1, 1, 16'h0111, 5'b00010);
        push_elem(1, 2, 16'h0112, 5'b01011);
        push_done();
        do_start(1'b1, 1, 2, 16'h0100, 16'h0010);
        wait_done("colfirst_2x3", 6);

        // Row-first 2x3
        push_elem(0, 0, 16'h0100, 5'b10100);
        push_elem(1, 0, 16'h0110, 5'b01100);
        push_elem(0, 1, 16'h0101, 5'b10000);
        push_elem(1, 1, 16'h0111, 5'b01000);
        push_elem(0, 2, 16'h0102, 5'b10010);
        push_elem(1, 2, 16'h0112, 5'b01011);
        push_done();
        do_start(1'b0, 1, 2, 16'h0100, 16'h0010);
        wait_done("rowfirst_2x3", 6);

        // Backpressure col-first 2x2: ready 1,0,0,1 repeating -> 4th transfer in T+8
        pat = 8'b1001_1001;
        push_matrix(1'b1, 1, 1, 16'h0040, 16'h0008);
        do_start(1'b1, 1, 1, 16'h0040, 16'h0008);
        for (int i = 0; i < 8; i++) begin
            out_ready = pat[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("backpressure_done_after_4th", 64'({done, out_valid}), 64'b10);
        wait_done("backpressure", 0);

        // 1x1 at top of address space
        push_elem(0, 0, 16'hFFFF, 5'b11111);
        push_done();
        do_start(1'b1, 0, 0, 16'hFFFF, 16'h0005);
        wait_done("one_by_one", 1);

        // 2x1 row-first: second address wraps
        push_elem(0, 0, 16'hFFFF, 5'b10110);
        push_elem(1, 0, 16'h0004, 5'b01111);
        push_done();
        do_start(1'b0, 1, 0, 16'hFFFF, 16'h0005);
        wait_done("wrap_2x1", 2);

        // Clear on the 3rd RUN cycle of a 4x4 run; no done may follow
        push_elem(0, 0, 16'h0200, 5'b10100);
        push_elem(0, 1, 16'h0201, 5'b00100);
        push_elem(0, 2, 16'h0202, 5'b00100);
        do_start(1'b1, 3, 3, 16'h0200, 16'h0020);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_valid_low", 64'({out_valid, done, busy}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("clear_no_done", 64'({out_valid, done}), 64'd0);

        // clear and start together in IDLE: clear wins
        is_col_first = 1'b1; num_row_m1 = 8'd1; num_col_m1 = 8'd1;
        base_addr = 16'h0500; row_stride = 16'h0001;
        start = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        chk("clear_beats_start", 64'({out_valid, busy}), 64'd0);

        // Restart after clear begins at (0,0)
        push_matrix(1'b1, 1, 1, 16'h0200, 16'h0020);
        do_start(1'b1, 1, 1, 16'h0200, 16'h0020);
        chk("restart_origin", 64'({out_row, out_col}), 64'd0);
        wait_done("restart", 4);

        // Start mid-run with a different num_col_m1 is ignored
        push_matrix(1'b1, 1, 2, 16'h0300, 16'h0040);
        do_start(1'b1, 1, 2, 16'h0300, 16'h0040);
        @(posedge clk); #1;
        @(posedge clk); #1;
        is_col_first = 1'b1; num_row_m1 = 8'd1; num_col_m1 = 8'd5;
        base_addr = 16'h0900; row_stride = 16'h0001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("midrun_start", 3);

        // Synchronous reset mid-run (stalled so nothing transfers)
        out_ready = 1'b0;
        do_start(1'b0, 3, 3, 16'h0700, 16'h0010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("midrun_reset");
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrun_reset_stays_idle", 64'({busy, done, out_valid}), 64'd0);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dca_matrix_sequencer.md
# dca_matrix_sequencer

Active element-stream generator for DCA matrix traversal: on a start pulse it walks an (num_row_m1+1) x (num_col_m1+1) matrix in row-major or column-major order and emits one element descriptor per valid/ready transfer. Each descriptor carries the row/column index, the linear address and first/last markers. Position-flag semantics match the DCA matrix iterator: x is the inner (fast) dimension and y is the outer one. The block sits in front of DCA load/store engines that consume per-element addresses with backpressure.

## Interface
- BW_NUM_ROW, 8, width of row index and num_row_m1
- BW_NUM_COL, 8, width of column index and num_col_m1
- BW_ADDR, 16, width of base_addr, row_stride and out_addr
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- clear  input  1  synchronous abort to IDLE
- start  input  1  start pulse; accepted only in IDLE
- is_col_first  input  1  1: column is inner (x=col); 0: row is inner (x=row)
- num_row_m1  input  BW_NUM_ROW  rows minus one
- num_col_m1  input  BW_NUM_COL  columns minus one
- base_addr  input  BW_ADDR  address of element (0,0)
- row_stride  input  BW_ADDR  address delta between consecutive rows
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the last transfer
- out_valid  output  1  descriptor valid
- out_ready  input  1  consumer accepts
- out_row  output  BW_NUM_ROW  row index
- out_col  output  BW_NUM_COL  column index
- out_addr  output  BW_ADDR  base_addr + out_row*row_stride + out_col, mod 2^BW_ADDR
- out_is_first_x, out_is_last_x, out_is_first_y, out_is_last_y  output  1 each  inner/outer boundary markers
- out_is_last_element  output  1  last row and last column

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start: latch is_col_first, num_row_m1, num_col_m1, base_addr and row_stride. Clear row and column to 0, set addr to base_addr, then go to RUN. Config inputs are ignored outside this cycle.
- RUN: out_valid=1. A transfer occurs when out_valid and out_ready are both high. On each transfer, advance the position:
  - col-first, not last col: col+1, addr+1.
  - col-first, last col: col=0, row+1. addr = row_base + row_stride, where row_base is a register holding the address of the current row's column 0.
  - row-first, not last row: row+1, addr+row_stride.
  - row-first, last row: row=0, col+1, addr = base + col + 1. Use a register holding the column-0-row-0 offset plus the column; no multiplier is permitted.
  - Transfer with out_is_last_element=1: go to DONE. Indices are not required to advance.
- DONE: done=1 and out_valid=0 for one cycle, then IDLE.
- start outside IDLE is ignored. A start in the same cycle as DONE is ignored.
- clear (any state): go to IDLE, out_valid=0, done=0; no done pulse is produced. If clear and start are both high in IDLE, clear wins.
- Flag semantics:
  - first_x/last_x refer to col when is_col_first=1, and to row otherwise.
  - y refers to the other index.
  - last flags compare against the latched num_*_m1.
- All address arithmetic wraps modulo 2^BW_ADDR. Index counters never exceed num_*_m1.
- Degenerate 1x1 matrix: a single descriptor with all five flags high.

## Timing
- rst values: state IDLE, busy=0, done=0, out_valid=0, out_row=0, out_col=0, out_addr=0. All out_is_* flags are 0 because they are gated by out_valid.
- Latency: start in cycle T gives out_valid=1 in T+1, with the first descriptor (0,0,base_addr).
- out_ready=1 continuously gives one descriptor per cycle. An N-element matrix occupies N cycles of RUN. done is high in cycle T+1+N, and IDLE resumes at T+2+N.
- While out_valid=1 and out_ready=0, every out_* signal is held stable.
- out_valid never drops in RUN without a transfer, except on clear or rst.
- done is never high in the same cycle as out_valid.
- All outputs are registered. out_* flags are decoded from registered indices; there is no combinational path from out_ready to out_valid.

## Test plan
- Col-first 2x3, base=0x100, stride=0x10, out_ready=1 → addrs 0x100,0x101,0x102,0x110,0x111,0x112. last_x on elements 3 and 6. last_element on element 6 only. done at T+7.
- Same config with row-first → (r,c) order (0,0),(1,0),(0,1),(1,1),(0,2),(1,2). Addrs 0x100,0x110,0x101,0x111,0x102,0x112. first_y on the first two elements.
- Backpressure: col-first 2x2 with out_ready toggling 1,0,0,1,… → exactly 4 transfers, outputs held during stalls, no duplicated or skipped element, done one cycle after the 4th transfer.
- 1x1 matrix, base=0xFFFF, stride=5, BW_ADDR=16 → one descriptor at addr 0xFFFF with all flags high. Separately, a 2x1 row-first case checks that the second addr wraps to 0x0004.
- clear asserted on the 3rd RUN cycle of a 4x4 run → out_valid=0 next cycle, no done pulse. A new start then restarts from (0,0).
- start pulsed mid-run with different num_col_m1 → ignored; the original traversal completes unchanged. Synchronous rst mid-run gives all outputs at reset values the next cycle.
